// File: rtl/shaper_filter_cfg.sv
// Trapezoidal pulse shaper with run-time configuration.
// Four-stage pipeline: d, p, q+m1*p, s/saturate.
module shaper_filter_cfg #(
  parameter  int SIZE_ADC_DATA    = 11,
  parameter  int SIZE_FILTER_DATA = 15,
  parameter  int ACC_W            = 40,
  parameter  int MAX_K            = 32,
  parameter  int K_DEF            = 4,
  parameter  int L_DEF            = 2,
  parameter  int M1_DEF           = 1,
  parameter  int M2_DEF           = 0,
  parameter  int SHIFT_DEF        = 0,
  localparam int KW               = $clog2(MAX_K + 1)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [SIZE_ADC_DATA:0]           input_data,
  input  logic                             in_valid,
  input  logic                             cfg_load,
  input  logic [KW-1:0]                    cfg_k,
  input  logic [KW-1:0]                    cfg_l,
  input  logic [15:0]                      cfg_m1,
  input  logic [15:0]                      cfg_m2,
  input  logic [5:0]                       cfg_shift,
  output logic signed [SIZE_FILTER_DATA:0] output_data,
  output logic                             out_valid,
  output logic                             cfg_err,
  output logic                             sat_flag,
  output logic                             warming
);

  localparam int XW = SIZE_ADC_DATA + 1;
  localparam int OW = SIZE_FILTER_DATA + 1;

  typedef logic signed [ACC_W-1:0] acc_t;
  typedef enum logic {WARMUP, RUN} state_t;

  localparam acc_t OMAX =
    {{(ACC_W-SIZE_FILTER_DATA){1'b0}}, {SIZE_FILTER_DATA{1'b1}}};
  localparam acc_t OMIN =
    {{(ACC_W-SIZE_FILTER_DATA){1'b1}}, {SIZE_FILTER_DATA{1'b0}}};
  localparam logic [OW-1:0] OUT_MAX = {1'b0, {SIZE_FILTER_DATA{1'b1}}};
  localparam logic [OW-1:0] OUT_MIN = {1'b1, {SIZE_FILTER_DATA{1'b0}}};
  localparam logic [KW-1:0] KMAX = KW'(MAX_K);

  function automatic acc_t zext(input logic [XW-1:0] v);
    return acc_t'({{(ACC_W-XW){1'b0}}, v});
  endfunction

  state_t        state_q, state_d;
  logic [KW-1:0] k_q, k_d, l_q, l_d, cnt_q, cnt_d;
  logic [15:0]   m1_q, m1_d, m2_q, m2_d;
  logic [5:0]    sh_q, sh_d;
  logic [XW-1:0] dl_q [MAX_K+1];
  logic [XW-1:0] dl_d [MAX_K+1];
  logic          v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic          e1_q, e1_d, e2_q, e2_d, e3_q, e3_d;
  acc_t          d1_q, d1_d, p_q, p_d, q_q, q_d;
  acc_t          mp_q, mp_d, s_q, s_d;
  logic          ov_q, ov_d, err_q, err_d, sat_q, sat_d;
  logic [OW-1:0] od_q, od_d;

  logic          acc, cfg_ok, clamp_hi, clamp_lo;
  logic [KW-1:0] k_idx, l_idx;
  acc_t          x_n, x_k, x_l, x_l1, k_ext, d_n;
  acc_t          m1_ext, m2_ext, m1p, m2p, s_nx, s_sh;
  logic [OW-1:0] o_sat;

  // Datapath: tap selection, difference term, products, saturation.
  always_comb begin
    acc      = in_valid && !cfg_load;
    cfg_ok   = (cfg_k != '0) && (cfg_k <= KMAX) && (cfg_l < cfg_k);
    k_idx    = k_q - KW'(1);
    l_idx    = l_q - KW'(1);
    x_n      = zext(input_data);
    x_k      = zext(dl_q[k_idx]);
    x_l      = (l_q == '0) ? x_n : zext(dl_q[l_idx]);
    x_l1     = zext(dl_q[l_q]);
    k_ext    = acc_t'({{(ACC_W-KW){1'b0}}, k_q});
    d_n      = x_n - x_k - k_ext * (x_l - x_l1);
    m1_ext   = acc_t'({{(ACC_W-16){1'b0}}, m1_q});
    m2_ext   = acc_t'({{(ACC_W-16){1'b0}}, m2_q});
    m1p      = p_q * m1_ext;
    m2p      = p_q * m2_ext;
    s_nx     = s_q + q_q + mp_q;
    s_sh     = s_nx >>> sh_q;
    clamp_hi = s_sh > OMAX;
    clamp_lo = s_sh < OMIN;
    o_sat    = s_sh[OW-1:0];
    if (clamp_hi) o_sat = OUT_MAX;
    if (clamp_lo) o_sat = OUT_MIN;
  end

  // Next state: pipeline advance, warmup FSM, config load/clear.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    l_d     = l_q;
    m1_d    = m1_q;
    m2_d    = m2_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    dl_d    = dl_q;
    v1_d    = acc;
    e1_d    = acc && (state_q == RUN);
    d1_d    = acc ? d_n : d1_q;
    v2_d    = v1_q;
    e2_d    = e1_q;
    p_d     = v1_q ? p_q + d1_q : p_q;
    v3_d    = v2_q;
    e3_d    = e2_q;
    q_d     = v2_q ? q_q + m2p : q_q;
    mp_d    = v2_q ? m1p : mp_q;
    s_d     = v3_q ? s_nx : s_q;
    ov_d    = v3_q && e3_q;
    od_d    = ov_d ? o_sat : od_q;
    sat_d   = sat_q || (ov_d && (clamp_hi || clamp_lo));
    err_d   = 1'b0;
    if (acc) begin
      dl_d[0] = input_data;
      for (int i = 1; i <= MAX_K; i++) dl_d[i] = dl_q[i-1];
      if (state_q == WARMUP) begin
        if (cnt_q == k_idx) state_d = RUN;
        else cnt_d = cnt_q + KW'(1);
      end
    end
    if (cfg_load) begin
      if (cfg_ok) begin
        k_d     = cfg_k;
        l_d     = cfg_l;
        m1_d    = cfg_m1;
        m2_d    = cfg_m2;
        sh_d    = cfg_shift;
        for (int i = 0; i <= MAX_K; i++) dl_d[i] = '0;
        v1_d    = 1'b0;
        v2_d    = 1'b0;
        v3_d    = 1'b0;
        e1_d    = 1'b0;
        e2_d    = 1'b0;
        e3_d    = 1'b0;
        d1_d    = '0;
        p_d     = '0;
        q_d     = '0;
        mp_d    = '0;
        s_d     = '0;
        ov_d    = 1'b0;
        od_d    = od_q;
        sat_d   = 1'b0;
        cnt_d   = '0;
        state_d = WARMUP;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // State registers with synchronous reset to default configuration.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WARMUP;
      k_q     <= KW'(K_DEF);
      l_q     <= KW'(L_DEF);
      m1_q    <= 16'(M1_DEF);
      m2_q    <= 16'(M2_DEF);
      sh_q    <= 6'(SHIFT_DEF);
      cnt_q   <= '0;
      for (int i = 0; i <= MAX_K; i++) dl_q[i] <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      e1_q    <= 1'b0;
      e2_q    <= 1'b0;
      e3_q    <= 1'b0;
      d1_q    <= '0;
      p_q     <= '0;
      q_q     <= '0;
      mp_q    <= '0;
      s_q     <= '0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      err_q   <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      l_q     <= l_d;
      m1_q    <= m1_d;
      m2_q    <= m2_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      dl_q    <= dl_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      v3_q    <= v3_d;
      e1_q    <= e1_d;
      e2_q    <= e2_d;
      e3_q    <= e3_d;
      d1_q    <= d1_d;
      p_q     <= p_d;
      q_q     <= q_d;
      mp_q    <= mp_d;
      s_q     <= s_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      err_q   <= err_d;
      sat_q   <= sat_d;
    end
  end

  assign output_data = $signed(od_q);
  assign out_valid   = ov_q;
  assign cfg_err     = err_q;
  assign sat_flag    = sat_q;
  assign warming     = (state_q == WARMUP);

endmodule
